// File: rtl/uart_cmd_ctrl.sv
// UART command framer: parses SYNC0 SYNC1 ADDR DATA_H DATA_L CHK frames into register writes,
// rejecting frames with a bad checksum or an idle gap longer than TIMEOUT_CYC.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [7:0]  SYNC0       = 8'h55,
    parameter logic [7:0]  SYNC1       = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        cfg_wr_en,
    output logic [7:0]  cfg_addr,
    output logic [15:0] cfg_wr_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [7:0]  ok_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned GapW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ErrChecksum = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StAddr,
        StDh,
        StDl,
        StChk
    } state_e;

    state_e          state_q;
    logic [GapW-1:0] gap_q;
    logic [7:0]      addr_q;
    logic [7:0]      dh_q;
    logic [7:0]      dl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gap_q       <= '0;
            addr_q      <= 8'h00;
            dh_q        <= 8'h00;
            dl_q        <= 8'h00;
            cfg_wr_en   <= 1'b0;
            cfg_addr    <= 8'h00;
            cfg_wr_data <= 16'h0000;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            busy        <= 1'b0;
            ok_cnt      <= 8'h00;
            err_cnt     <= 8'h00;
        end else begin
            cfg_wr_en <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid) begin
                // A byte always wins over a coincident timeout.
                gap_q <= '0;
                case (state_q)
                    StIdle: begin
                        if (rx_byte == SYNC0) begin
                            state_q <= StSync;
                            busy    <= 1'b1;
                        end
                    end
                    StSync: begin
                        if (rx_byte == SYNC1) begin
                            state_q <= StAddr;
                        end else if (rx_byte != SYNC0) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                    StAddr: begin
                        addr_q  <= rx_byte;
                        state_q <= StDh;
                    end
                    StDh: begin
                        dh_q    <= rx_byte;
                        state_q <= StDl;
                    end
                    StDl: begin
                        dl_q    <= rx_byte;
                        state_q <= StChk;
                    end
                    StChk: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        if (rx_byte == (addr_q ^ dh_q ^ dl_q)) begin
                            cfg_wr_en   <= 1'b1;
                            frame_ok    <= 1'b1;
                            cfg_addr    <= addr_q;
                            cfg_wr_data <= {dh_q, dl_q};
                            ok_cnt      <= ok_cnt + 8'd1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ErrChecksum;
                            err_cnt   <= err_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end else if (state_q != StIdle) begin
                if (gap_q == GapLast) begin
                    state_q   <= StIdle;
                    busy      <= 1'b0;
                    gap_q     <= '0;
                    frame_err <= 1'b1;
                    err_code  <= ErrTimeout;
                    err_cnt   <= err_cnt + 8'd1;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame accept/reject, timeout boundary, counter wrap, reset.
module tb_uart_cmd_ctrl;

    localparam int unsigned Tmo = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cfg_wr_en;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_wr_data;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [7:0]  ok_cnt;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor and values sampled one cycle after each strobe
    int          wr_seen = 0;
    int          err_seen = 0;
    int          pair_bad = 0;
    logic [31:0] wr_sum = 0;
    logic        post_wr;
    logic        post_err;

    uart_cmd_ctrl #(
        .TIMEOUT_CYC(Tmo),
        .SYNC0      (8'h55),
        .SYNC1      (8'hAA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_addr   (cfg_addr),
        .cfg_wr_data(cfg_wr_data),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy),
        .ok_cnt     (ok_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_wr_en) begin
            wr_seen = wr_seen + 1;
            wr_sum  = wr_sum + {8'h00, cfg_addr, cfg_wr_data};
        end
        if (frame_ok !== cfg_wr_en) pair_bad = pair_bad + 1;
        if (frame_err) err_seen = err_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One strobe followed by the minimum two idle cycles
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        post_wr  = cfg_wr_en;
        post_err = frame_err;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(a);
        send_byte(dh);
        send_byte(dl);
        send_byte(a ^ dh ^ dl);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wr"}, {31'd0, cfg_wr_en}, 0);
        check({tag, "_ok"}, {31'd0, frame_ok}, 0);
        check({tag, "_err"}, {31'd0, frame_err}, 0);
        check({tag, "_addr"}, {24'd0, cfg_addr}, 0);
        check({tag, "_data"}, {16'd0, cfg_wr_data}, 0);
        check({tag, "_code"}, {30'd0, err_code}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_okcnt"}, {24'd0, ok_cnt}, 0);
        check({tag, "_errcnt"}, {24'd0, err_cnt}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          found;
        logic [31:0] exp_sum;
        logic [7:0]  a, dh, dl;

        idle(3);
        check_reset_state("rst");
        rst_n = 1'b1;
        idle(2);

        // Valid frame
        send_frame(8'h12, 8'h34, 8'h56);
        check("t1_wr_next", {31'd0, post_wr}, 1);
        check("t1_addr", {24'd0, cfg_addr}, 32'h12);
        check("t1_data", {16'd0, cfg_wr_data}, 32'h3456);
        check("t1_okcnt", {24'd0, ok_cnt}, 1);
        check("t1_busy", {31'd0, busy}, 0);

        // Bad checksum
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h71);
        check("t2_err_next", {31'd0, post_err}, 1);
        check("t2_code", {30'd0, err_code}, 32'h1);
        check("t2_errcnt", {24'd0, err_cnt}, 1);
        check("t2_wr_seen", wr_seen, 1);
        check("t2_addr_hold", {24'd0, cfg_addr}, 32'h12);

        // Timeout after ADDR
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h12);
        check("t3_busy_pre", {31'd0, busy}, 1);
        found = -1;
        for (int i = 0; i < Tmo + 10; i++) begin
            @(negedge clk);
            if (frame_err && found < 0) found = i;
        end
        check("t3_tmo_cycle", found, Tmo - 2);
        check("t3_code", {30'd0, err_code}, 32'h2);
        check("t3_errcnt", {24'd0, err_cnt}, 2);
        check("t3_busy", {31'd0, busy}, 0);
        send_frame(8'h21, 8'hC0, 8'h0F);
        check("t3_okcnt_after", {24'd0, ok_cnt}, 2);
        check("t3_data_after", {16'd0, cfg_wr_data}, 32'hC00F);

        // Byte arrives exactly when the gap counter hits its limit: no timeout
        send_byte(8'h55); send_byte(8'hAA);
        idle(Tmo - 3);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h70);
        check("t4_errcnt", {24'd0, err_cnt}, 2);
        check("t4_okcnt", {24'd0, ok_cnt}, 3);

        // Leading junk and repeated SYNC0
        send_byte(8'h00); send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h03);
        check("t5_addr", {24'd0, cfg_addr}, 32'h01);
        check("t5_data", {16'd0, cfg_wr_data}, 32'h0002);
        check("t5_errcnt", {24'd0, err_cnt}, 2);
        check("t5_err_seen", err_seen, 2);
        check("t5_wr_seen", wr_seen, 4);

        // Reset mid-frame discards the partial frame
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h12); send_byte(8'h34);
        rst_n = 1'b0;
        idle(2);
        check_reset_state("t6_rst");
        rst_n = 1'b1;
        idle(2);
        send_byte(8'h56); send_byte(8'h70);
        idle(3);
        check("t6_wr_seen", wr_seen, 4);
        check("t6_err_seen", err_seen, 2);
        check("t6_busy", {31'd0, busy}, 0);
        check("t6_okcnt", {24'd0, ok_cnt}, 0);

        // 258 frames at minimum spacing: ok_cnt wraps to 2
        exp_sum = wr_sum;
        for (int i = 0; i < 258; i++) begin
            a  = 8'(i);
            dh = 8'(i * 3);
            dl = ~8'(i);
            send_frame(a, dh, dl);
            exp_sum = exp_sum + {8'h00, a, dh, dl};
        end
        check("t7_wr_seen", wr_seen, 4 + 258);
        check("t7_sum", wr_sum, exp_sum);
        check("t7_okcnt", {24'd0, ok_cnt}, 2);
        check("t7_errcnt", {24'd0, err_cnt}, 0);
        check("t7_pair", pair_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: idle-gap limit in clk cycles between bytes of one frame (1 ms at 50 MHz).
REQ-002 Parameter SYNC0, default 8'h55: first frame sync byte.
REQ-003 Parameter SYNC1, default 8'hAA: second frame sync byte.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 rx_byte  input  8  received byte from the UART receiver, stable while rx_valid is high.
REQ-007 rx_valid  input  1  single-cycle strobe, one per received byte; at least 2 idle cycles between strobes.
REQ-008 cfg_wr_en  output  1  single-cycle register-write strobe.
REQ-009 cfg_addr  output  8  register address, valid while cfg_wr_en is high.
REQ-010 cfg_wr_data  output  16  register write data, valid while cfg_wr_en is high.
REQ-011 frame_ok  output  1  single-cycle pulse for each accepted frame, coincident with cfg_wr_en.
REQ-012 frame_err  output  1  single-cycle pulse for each rejected frame.
REQ-013 err_code  output  2  cause of last rejection: 01 checksum, 10 timeout; holds until the next frame_err.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 ok_cnt  output  8  count of accepted frames; wraps 255->0.
REQ-016 err_cnt  output  8  count of rejected frames; wraps 255->0.

Function
REQ-017 Frame format: SYNC0, SYNC1, ADDR, DATA_H, DATA_L, CHK.
REQ-018 Checksum rule: CHK = ADDR ^ DATA_H ^ DATA_L, computed over 8 bits.
REQ-019 FSM states: IDLE, SYNC, ADDR, DH, DL, CHK; the FSM advances only on cycles with rx_valid=1.
REQ-020 Transitions:
- IDLE: rx_byte==SYNC0 -> SYNC; any other byte -> stay IDLE.
- SYNC: SYNC1 -> ADDR; SYNC0 -> stay SYNC; any other byte -> IDLE, no error.
- ADDR -> DH -> DL -> CHK, each capturing its byte.
REQ-021 On a byte in CHK with matching checksum, the FSM returns to IDLE. In the next clk cycle, cfg_wr_en=1, frame_ok=1, cfg_addr=ADDR and cfg_wr_data={DATA_H,DATA_L}, and ok_cnt increments.
REQ-022 On a byte in CHK with mismatching checksum, the FSM returns to IDLE. In the next cycle, frame_err=1 with err_code=01, err_cnt increments, and no write occurs.
REQ-023 The gap counter clears on every rx_valid and in IDLE, and increments each cycle in any other state.
REQ-024 When the gap counter reaches TIMEOUT_CYC-1 without rx_valid, the FSM enters IDLE. In the next cycle, frame_err=1 with err_code=10 and err_cnt increments.
REQ-025 If rx_valid and the timeout condition coincide, the byte takes priority and no timeout occurs.
REQ-026 A byte arriving in the cycle in which cfg_wr_en or frame_err is asserted is processed normally from IDLE (back-to-back frames).
REQ-027 cfg_addr and cfg_wr_data hold their last written values between writes.
REQ-028 All outputs are registered; there are no combinational input-to-output paths.

Reset
REQ-029 While rst_n=0:
- FSM=IDLE and the gap counter is 0.
- cfg_wr_en, frame_ok and frame_err are 0.
- cfg_addr=8'h00, cfg_wr_data=16'h0000, err_code=2'b00, busy=0, ok_cnt=0, err_cnt=0.
REQ-030 Reset asserted mid-frame discards the partial frame with no pulse output.
REQ-031 After release, the FSM requires a new SYNC0.

Verification
REQ-032 Bytes 55 AA 12 34 56 70 -> one cfg_wr_en with cfg_addr=12, cfg_wr_data=3456; frame_ok=1; ok_cnt=1.
REQ-033 Bytes 55 AA 12 34 56 71 -> frame_err with err_code=01; err_cnt=1; no cfg_wr_en.
REQ-034 Bytes 55 AA 12, then TIMEOUT_CYC idle cycles -> frame_err with err_code=10; busy=0; a following valid frame is accepted.
REQ-035 Bytes 00 55 55 AA 01 00 02 03 -> write with cfg_addr=01, cfg_wr_data=0002; no errors.
REQ-036 Two valid frames at minimum spacing, then 256 valid frames -> every write is seen; ok_cnt wraps to 02.
REQ-037 rst_n low after 55 AA 12 34, then release, then bytes 56 70 -> no write, no error, busy=0.
